// File: rtl/vpu_pathway_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vpu_pathway_sequencer                                                    |
// | Sequences one VPU operation: holds the pathway, starts the array, drains.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vpu_pathway_sequencer #(
  parameter int CNT_W         = 16,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_rows,
  output logic [3:0]       vpu_data_pathway,
  output logic             sys_start,
  input  logic             vpu_valid_in_1,
  input  logic             vpu_valid_in_2,
  input  logic             vpu_valid_out_1,
  input  logic             vpu_valid_out_2,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic             err_overflow,
  output logic [CNT_W-1:0] beats_out
);

  localparam int TMO_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] rows_q, rows_d;
  logic [CNT_W-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [CNT_W-1:0] out1_q, out1_d, out2_q, out2_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [3:0]       pathway_q, pathway_d;
  logic             sys_start_q, sys_start_d;
  logic             err_timeout_q, err_timeout_d;
  logic             ovf_q, ovf_d;

  logic in1_full, in2_full, out1_full, out2_full;

  assign in1_full  = (in1_q == rows_q);
  assign in2_full  = (in2_q == rows_q);
  assign out1_full = (out1_q == rows_q);
  assign out2_full = (out2_q == rows_q);

  function automatic logic [3:0] decode_mode(input logic [1:0] m);
    case (m)
      2'b00:   decode_mode = 4'b1100;
      2'b01:   decode_mode = 4'b1111;
      2'b10:   decode_mode = 4'b0001;
      default: decode_mode = 4'b0000;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    rows_d        = rows_q;
    in1_d         = in1_q;
    in2_d         = in2_q;
    out1_d        = out1_q;
    out2_d        = out2_q;
    tmo_d         = tmo_q;
    ovf_d         = ovf_q;
    sys_start_d   = 1'b0;
    err_timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          mode_d  = cmd_mode;
          rows_d  = cmd_rows;
          in1_d   = '0;
          in2_d   = '0;
          out1_d  = '0;
          out2_d  = '0;
          tmo_d   = '0;
          ovf_d   = 1'b0;
          state_d = (cmd_rows == '0) ? DONE : SETUP;
        end
      end
      SETUP: begin
        state_d     = STREAM;
        sys_start_d = 1'b1;
      end
      STREAM: begin
        if (vpu_valid_in_1) begin
          if (in1_full) ovf_d = 1'b1;
          else          in1_d = in1_q + CNT_W'(1);
        end
        if (vpu_valid_in_2) begin
          if (in2_full) ovf_d = 1'b1;
          else          in2_d = in2_q + CNT_W'(1);
        end
        if (in1_full && in2_full) begin
          state_d = DRAIN;
          tmo_d   = '0;
        end
      end
      DRAIN: begin
        // Inputs after the last expected beat are never counted.
        if (vpu_valid_in_1 || vpu_valid_in_2) ovf_d = 1'b1;
        if (vpu_valid_out_1 || vpu_valid_out_2) tmo_d = '0;
        else                                    tmo_d = tmo_q + TMO_W'(1);
        if (out1_full && out2_full) begin
          state_d = DONE;
        end else if (tmo_q == TMO_MAX) begin
          state_d       = DONE;
          err_timeout_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == STREAM || state_q == DRAIN) begin
      if (vpu_valid_out_1) begin
        if (out1_full) ovf_d  = 1'b1;
        else           out1_d = out1_q + CNT_W'(1);
      end
      if (vpu_valid_out_2) begin
        if (out2_full) ovf_d  = 1'b1;
        else           out2_d = out2_q + CNT_W'(1);
      end
    end

    // Pathway is a pure function of the next state so it never glitches mid-op.
    if (state_d == SETUP || state_d == STREAM || state_d == DRAIN)
      pathway_d = decode_mode(mode_d);
    else
      pathway_d = 4'b0000;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      mode_q        <= 2'b00;
      rows_q        <= '0;
      in1_q         <= '0;
      in2_q         <= '0;
      out1_q        <= '0;
      out2_q        <= '0;
      tmo_q         <= '0;
      pathway_q     <= 4'b0000;
      sys_start_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      rows_q        <= rows_d;
      in1_q         <= in1_d;
      in2_q         <= in2_d;
      out1_q        <= out1_d;
      out2_q        <= out2_d;
      tmo_q         <= tmo_d;
      pathway_q     <= pathway_d;
      sys_start_q   <= sys_start_d;
      err_timeout_q <= err_timeout_d;
      ovf_q         <= ovf_d;
    end
  end

  assign cmd_ready        = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign sys_start        = sys_start_q;
  assign err_timeout      = err_timeout_q;
  assign err_overflow     = ovf_q;
  assign beats_out        = out1_q;
  assign vpu_data_pathway = pathway_q;

endmodule
`default_nettype wire

// File: tb/tb_vpu_pathway_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vpu_pathway_sequencer                                                 |
// | Directed vector table plus hand-written timeout and reset sequences.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vpu_pathway_sequencer;

  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_mode;
  logic [CW-1:0] cmd_rows;
  logic [3:0]    vpu_data_pathway;
  logic          sys_start;
  logic          vin1, vin2, vout1, vout2;
  logic          busy, done, err_timeout, err_overflow;
  logic [CW-1:0] beats_out;

  int n_pass  = 0;
  int n_total = 0;

  vpu_pathway_sequencer #(.CNT_W(CW), .DRAIN_TIMEOUT(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_mode         (cmd_mode),
    .cmd_rows         (cmd_rows),
    .vpu_data_pathway (vpu_data_pathway),
    .sys_start        (sys_start),
    .vpu_valid_in_1   (vin1),
    .vpu_valid_in_2   (vin2),
    .vpu_valid_out_1  (vout1),
    .vpu_valid_out_2  (vout2),
    .busy             (busy),
    .done             (done),
    .err_timeout      (err_timeout),
    .err_overflow     (err_overflow),
    .beats_out        (beats_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // valids = {in1, in2, out1, out2}; flags = {start, busy, done, eto, ovf, rdy}
  typedef struct {
    logic          cv;
    logic [1:0]    mode;
    logic [CW-1:0] rows;
    logic [3:0]    valids;
    logic [3:0]    e_path;
    logic [5:0]    e_flags;
    logic [CW-1:0] e_beats;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic cv, input logic [1:0] mode, input int rows,
                             input logic [3:0] valids, input logic [3:0] path,
                             input logic [5:0] flags, input int beats);
    vec_t r;
    r.cv = cv; r.mode = mode; r.rows = CW'(rows); r.valids = valids;
    r.e_path = path; r.e_flags = flags; r.e_beats = CW'(beats);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic cv, input logic [1:0] mode, input int rows,
                       input logic [3:0] valids);
    cmd_valid = cv;
    cmd_mode  = mode;
    cmd_rows  = CW'(rows);
    {vin1, vin2, vout1, vout2} = valids;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {6'd0, vpu_data_pathway, sys_start, busy, done, err_timeout, err_overflow,
            cmd_ready, beats_out};
  endfunction

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b00, 0, 4'b0000);
    #1 rst = 1'b0;
    tick();
    tick();
    chk("reset_state", outs(), {6'd0, 4'h0, 6'b000001, 16'd0});
    rst = 1'b1;

    // forward, rows=4, outputs trail inputs by 2 cycles
    vecs.push_back(v(1, 2'b00, 4, 4'b0000, 4'hC, 6'b010000, 0));
    vecs.push_back(v(0, 2'b00, 0, 4'b0000, 4'hC, 6'b110000, 0));
    vecs.push_back(v(0, 2'b00, 0, 4'b1100, 4'hC, 6'b010000, 0));
    vecs.push_back(v(0, 2'b00, 0, 4'b1100, 4'hC, 6'b010000, 0));
    vecs.push_back(v(0, 2'b00, 0, 4'b1111, 4'hC, 6'b010000, 1));
    vecs.push_back(v(0, 2'b00, 0, 4'b1111, 4'hC, 6'b010000, 2));
    vecs.push_back(v(0, 2'b00, 0, 4'b0011, 4'hC, 6'b010000, 3));
    vecs.push_back(v(0, 2'b00, 0, 4'b0011, 4'hC, 6'b010000, 4));
    vecs.push_back(v(0, 2'b00, 0, 4'b0000, 4'h0, 6'b011000, 4));
    vecs.push_back(v(0, 2'b00, 0, 4'b0000, 4'h0, 6'b000001, 4));
    // transition, rows=3, lane 2 lags lane 1 by one cycle
    vecs.push_back(v(1, 2'b01, 3, 4'b0000, 4'hF, 6'b010000, 0));
    vecs.push_back(v(0, 2'b00, 0, 4'b0000, 4'hF, 6'b110000, 0));
    vecs.push_back(v(0, 2'b00, 0, 4'b1000, 4'hF, 6'b010000, 0));
    vecs.push_back(v(0, 2'b00, 0, 4'b1100, 4'hF, 6'b010000, 0));
    vecs.push_back(v(0, 2'b00, 0, 4'b1110, 4'hF, 6'b010000, 1));
    vecs.push_back(v(0, 2'b00, 0, 4'b0111, 4'hF, 6'b010000, 2));
    vecs.push_back(v(0, 2'b00, 0, 4'b0011, 4'hF, 6'b010000, 3));
    vecs.push_back(v(0, 2'b00, 0, 4'b0001, 4'hF, 6'b010000, 3));
    vecs.push_back(v(0, 2'b00, 0, 4'b0000, 4'h0, 6'b011000, 3));
    vecs.push_back(v(0, 2'b00, 0, 4'b0000, 4'h0, 6'b000001, 3));
    // backward, rows=2, extra lane-1 input beat -> sticky overflow
    vecs.push_back(v(1, 2'b10, 2, 4'b0000, 4'h1, 6'b010000, 0));
    vecs.push_back(v(0, 2'b00, 0, 4'b0000, 4'h1, 6'b110000, 0));
    vecs.push_back(v(0, 2'b00, 0, 4'b1100, 4'h1, 6'b010000, 0));
    vecs.push_back(v(0, 2'b00, 0, 4'b1100, 4'h1, 6'b010000, 0));
    vecs.push_back(v(0, 2'b00, 0, 4'b1011, 4'h1, 6'b010010, 1));
    vecs.push_back(v(0, 2'b00, 0, 4'b0011, 4'h1, 6'b010010, 2));
    vecs.push_back(v(0, 2'b00, 0, 4'b0000, 4'h0, 6'b011010, 2));
    vecs.push_back(v(0, 2'b00, 0, 4'b0000, 4'h0, 6'b000011, 2));
    // rows=0 accept clears overflow and completes at once; next command held
    vecs.push_back(v(1, 2'b00, 0, 4'b0000, 4'h0, 6'b011000, 0));
    vecs.push_back(v(1, 2'b01, 1, 4'b0000, 4'h0, 6'b000001, 0));
    vecs.push_back(v(1, 2'b01, 1, 4'b0000, 4'hF, 6'b010000, 0));
    vecs.push_back(v(0, 2'b00, 0, 4'b0000, 4'hF, 6'b110000, 0));
    vecs.push_back(v(0, 2'b00, 0, 4'b1100, 4'hF, 6'b010000, 0));
    vecs.push_back(v(0, 2'b00, 0, 4'b0011, 4'hF, 6'b010000, 1));
    vecs.push_back(v(0, 2'b00, 0, 4'b0000, 4'h0, 6'b011000, 1));
    vecs.push_back(v(0, 2'b00, 0, 4'b0000, 4'h0, 6'b000001, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cv, vecs[i].mode, int'(vecs[i].rows), vecs[i].valids);
      tick();
      chk($sformatf("vec%0d", i), outs(),
          {6'd0, vecs[i].e_path, vecs[i].e_flags, vecs[i].e_beats});
    end

    // passthrough rows=5: lane-2 output stops at 4 beats, drain times out
    drive(1'b1, 2'b11, 5, 4'b0000); tick();
    chk("to_setup_busy", {31'd0, busy}, 32'd1);
    drive(1'b0, 2'b00, 0, 4'b0000); tick();
    chk("to_sys_start", {31'd0, sys_start}, 32'd1);
    drive(1'b0, 2'b00, 0, 4'b1100); tick();
    drive(1'b0, 2'b00, 0, 4'b1100); tick();
    drive(1'b0, 2'b00, 0, 4'b1111); tick();
    drive(1'b0, 2'b00, 0, 4'b1111); tick();
    drive(1'b0, 2'b00, 0, 4'b1111); tick();
    drive(1'b0, 2'b00, 0, 4'b0011); tick();
    drive(1'b0, 2'b00, 0, 4'b0010); tick();
    chk("to_beats5_pre", {16'd0, beats_out}, 32'd5);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 2'b00, 0, 4'b0000); tick();
      chk($sformatf("to_idle%0d_done_eto", k), {30'd0, done, err_timeout},
          (k == 8) ? 32'd3 : 32'd0);
    end
    chk("to_beats_out", {16'd0, beats_out}, 32'd5);
    chk("to_no_overflow", {31'd0, err_overflow}, 32'd0);
    tick();
    chk("to_after_done", {29'd0, done, err_timeout, cmd_ready}, 32'd1);

    // reset asserted mid-STREAM in forward mode
    drive(1'b1, 2'b00, 4, 4'b0000); tick();
    drive(1'b0, 2'b00, 0, 4'b0000); tick();
    drive(1'b0, 2'b00, 0, 4'b1100); tick();
    chk("rs_stream_path", {28'd0, vpu_data_pathway}, 32'hC);
    drive(1'b0, 2'b00, 0, 4'b0000);
    #3 rst = 1'b0;
    #1;
    chk("rs_async_path_busy", {27'd0, vpu_data_pathway, busy}, 32'd0);
    tick();
    chk("rs_held_no_done", {30'd0, done, busy}, 32'd0);
    rst = 1'b1;
    tick();
    chk("rs_after_release", {26'd0, vpu_data_pathway, busy, cmd_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
